sync_handshake_data: RTL and testbench
======================================

// Module: sync_handshake_data
// PURPOSE
//  Source-initiated, multi-bit clock-domain crossing. It uses the same two-phase toggle request/acknowledge protocol
//  as the pulse synchronizer, extended to carry a DATA_W-bit word from clk_src to clk_dst.
//  Source side: captures a word on valid/ready, holds it stable and toggles req, then waits for the returned ack
//  toggle before accepting the next word.
//  Used by the Xillybus-side control path to pass configuration/command words into the GZIP core clock domain.
// PARAMETERS
//  DATA_W       32  width of transferred word
//  SYNC_STAGES  2   synchronizer flops per crossing (legal: 2 or 3)
//  CNT_W        16  width of completed-transfer counter (wraps)
// PORTS
//  clk_src    in   1       source clock
//  rst_n      in   1       reset, asynchronous, active-low; resets both domains
//  clk_dst    in   1       destination clock
//  src_valid  in   1       word offered on src_data (clk_src)
//  src_data   in   DATA_W  word to transfer (clk_src)
//  src_ready  out  1       block can accept a word this clk_src cycle
//  src_done   out  1       1-cycle clk_src pulse: ack received, transfer complete
//  xfer_cnt   out  CNT_W   completed transfers (clk_src), increments with src_done
//  dst_valid  out  1       1-cycle clk_dst pulse: new word on dst_data
//  dst_data   out  DATA_W  last received word, held until next dst_valid (clk_dst)
// BEHAVIOUR
//  Reset (async, both domains):
//   - state=IDLE, req_tg=0, ack_tg=0, all sync/edge flops=0, hold reg=0.
//   - Outputs: src_ready=1, src_done=0, xfer_cnt=0, dst_valid=0, dst_data=0.
//  Source FSM (clk_src), src_ready = (state==IDLE):
//   - IDLE: on src_valid&&src_ready, at that edge: hold<=src_data, req_tg<=~req_tg, state<=WAIT.
//   - WAIT: src_valid ignored. When ack_pl (see below) is seen, at that edge: state<=IDLE, src_done<=1, xfer_cnt<=xfer_cnt+1.
//  hold must not change while in WAIT. It is the only clk_src-domain source of dst_data.
//  Dst side (clk_dst):
//   - req_tg passes through SYNC_STAGES flops, then one edge flop; req_pl = last_sync ^ edge_flop.
//   - On req_pl, at that edge: dst_data<=hold (quasi-static, no sync needed), dst_valid<=1, ack_tg<=~ack_tg.
//   - dst_valid is 0 in every other cycle. There is no dst backpressure.
//  Ack return (clk_src): ack_tg passes through SYNC_STAGES flops, then an edge flop; ack_pl = last_sync ^ edge_flop.
//  Latency (SYNC_STAGES=2), req toggled at clk_src edge S0:
//   - dst_valid and dst_data are valid in the cycle after the 3rd clk_dst edge following S0.
//   - src_done occurs in the cycle after the 3rd clk_src edge following the ack toggle.
//   - Next accept happens one cycle later.
//   - Each extra SYNC_STAGE adds 1 cycle per crossing.
//  Boundaries:
//   - src_valid held high through WAIT: exactly one capture per round trip.
//   - src_valid in the same cycle as src_done: src_ready is already 1, so the word is accepted that cycle.
//     Back-to-back throughput = one word per full round trip.
//   - src_data changing while in WAIT: no effect on hold or dst_data.
//   - xfer_cnt wraps from 2^CNT_W-1 to 0 silently.
//   - Reset mid-transfer: both domains clear together, so toggles are equal.
//     No spurious dst_valid or src_done after release; the in-flight word is dropped.
//   - Clock ratios: correct for any ratio of clk_src to clk_dst.
//  Only req_tg and ack_tg cross domains through synchronizers. hold crosses as quasi-static data (constrain as false path/max-delay).
// TESTING
//  1. Reset, clk_src 100 MHz / clk_dst 37 MHz, send 0xDEADBEEF -> one dst_valid with dst_data=0xDEADBEEF,
//     one src_done, xfer_cnt=1, src_ready low from accept until src_done.
//  2. src_valid held high with an incrementing word each cycle for 100 transfers
//     -> dst sees exactly the accepted words, in order, with no duplicates or gaps; xfer_cnt=100.
//  3. Ratio sweep (dst 4x faster, dst 4x slower, equal with phase offset) with 1000 random words -> scoreboard match,
//     dst_valid exactly 1 clk_dst wide, src_done exactly 1 clk_src wide.
//  4. Toggle src_data every cycle while in WAIT -> dst_data equals the value captured at accept.
//  5. Assert rst_n after req toggles but before ack returns, then release -> no dst_valid or src_done after release;
//     src_ready=1; next word transfers normally.
//  6. CNT_W=4, run 17 transfers -> xfer_cnt=1; SYNC_STAGES=3 -> dst latency increases by exactly 1 clk_dst cycle.

Source files
------------

// File: rtl/sync_handshake_data.sv
// Multi-bit clk_src -> clk_dst crossing using a two-phase toggle req/ack handshake.
// The word is held quasi-static in the source domain while the toggles cross through synchronizers.
`timescale 1ns/10ps
module sync_handshake_data #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk_src,
  input  logic              rst_n,
  input  logic              clk_dst,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              src_done,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  // ---------------- source domain ----------------
  state_e                   state_q, state_d;
  logic                     req_tg_q, req_tg_d;
  logic [DATA_W-1:0]        hold_q, hold_d;
  logic                     src_done_q, src_done_d;
  logic [CNT_W-1:0]         xfer_cnt_q, xfer_cnt_d;
  logic [SYNC_STAGES-1:0]   ack_sync_q;
  logic                     ack_edge_q;
  logic                     ack_pl;

  // ---------------- destination domain ----------------
  logic [SYNC_STAGES-1:0]   req_sync_q;
  logic                     req_edge_q;
  logic                     req_pl;
  logic                     ack_tg_q, ack_tg_d;
  logic                     dst_valid_q, dst_valid_d;
  logic [DATA_W-1:0]        dst_data_q, dst_data_d;

  assign ack_pl = ack_sync_q[SYNC_STAGES-1] ^ ack_edge_q;
  assign req_pl = req_sync_q[SYNC_STAGES-1] ^ req_edge_q;

  // NOTE: every always_comb output gets a default first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    req_tg_d   = req_tg_q;
    hold_d     = hold_q;
    src_done_d = 1'b0;
    xfer_cnt_d = xfer_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (src_valid) begin
          hold_d   = src_data;
          req_tg_d = ~req_tg_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // hold_q stays frozen here: dst samples it without synchronization
        if (ack_pl) begin
          state_d    = S_IDLE;
          src_done_d = 1'b1;
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_tg_q   <= 1'b0;
      hold_q     <= '0;
      src_done_q <= 1'b0;
      xfer_cnt_q <= '0;
      ack_sync_q <= '0;
      ack_edge_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_tg_q   <= req_tg_d;
      hold_q     <= hold_d;
      src_done_q <= src_done_d;
      xfer_cnt_q <= xfer_cnt_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tg_q};
      ack_edge_q <= ack_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    ack_tg_d    = ack_tg_q ^ req_pl;
    dst_valid_d = req_pl;
    dst_data_d  = dst_data_q;
    if (req_pl) dst_data_d = hold_q;
  end

  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q  <= '0;
      req_edge_q  <= 1'b0;
      ack_tg_q    <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
    end else begin
      req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], req_tg_q};
      req_edge_q  <= req_sync_q[SYNC_STAGES-1];
      ack_tg_q    <= ack_tg_d;
      dst_valid_q <= dst_valid_d;
      dst_data_q  <= dst_data_d;
    end
  end

  assign src_ready = (state_q == S_IDLE);
  assign src_done  = src_done_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign dst_valid = dst_valid_q;
  assign dst_data  = dst_data_q;

endmodule

// File: tb/tb_sync_handshake_data.sv
// Directed bench for sync_handshake_data: scenario tasks with inline comparisons,
// plus monitors that score every delivered word and the width of each pulse.
`timescale 1ns/10ps
module tb_sync_handshake_data;

  logic        clk_src = 1'b0;
  logic        clk_dst = 1'b0;
  logic        rst_n   = 1'b0;
  realtime     dst_half = 13.5;

  logic        src_valid = 1'b0;
  logic [31:0] src_data  = '0;
  logic        src_ready, src_done, dst_valid;
  logic [15:0] xfer_cnt;
  logic [31:0] dst_data;

  logic        src_valid1 = 1'b0;
  logic [31:0] src_data1  = '0;
  logic        src_ready1, src_done1, dst_valid1;
  logic [3:0]  xfer_cnt1;
  logic [31:0] dst_data1;

  int          checks = 0;
  int          errors = 0;
  int          n_dv   = 0;
  int          n_done = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;
  logic        prev_dv = 1'b0;
  logic        prev_done = 1'b0;

  sync_handshake_data #(.DATA_W(32), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
    .clk_src(clk_src), .rst_n(rst_n), .clk_dst(clk_dst),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .src_done(src_done), .xfer_cnt(xfer_cnt),
    .dst_valid(dst_valid), .dst_data(dst_data)
  );

  sync_handshake_data #(.DATA_W(32), .SYNC_STAGES(3), .CNT_W(4)) u_dut3 (
    .clk_src(clk_src), .rst_n(rst_n), .clk_dst(clk_dst),
    .src_valid(src_valid1), .src_data(src_data1), .src_ready(src_ready1),
    .src_done(src_done1), .xfer_cnt(xfer_cnt1),
    .dst_valid(dst_valid1), .dst_data(dst_data1)
  );

  always #5 clk_src = ~clk_src;
  initial forever begin
    #(dst_half);
    clk_dst = ~clk_dst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source monitor: record accepted words, check src_done is one cycle wide.
  always @(negedge clk_src) begin
    if (src_valid && src_ready) sb.push_back(src_data);
    if (src_done) begin
      n_done++;
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL src_done_width: high on consecutive clk_src cycles, required 1-cycle pulse");
      end
    end
    prev_done = src_done;
  end

  // Destination monitor: every dst_valid must deliver the oldest outstanding word.
  always @(negedge clk_dst) begin
    if (dst_valid) begin
      n_dv++;
      checks++;
      if (prev_dv) begin
        errors++;
        $display("FAIL dst_valid_width: high on consecutive clk_dst cycles, required 1-cycle pulse");
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL dst_spurious: dst_valid with dst_data=%h, required no word outstanding", dst_data);
      end else begin
        mon_exp = sb.pop_front();
        if (dst_data !== mon_exp) begin
          errors++;
          $display("FAIL dst_data: got %h, required %h", dst_data, mon_exp);
        end
      end
    end
    prev_dv = dst_valid;
  end

  task automatic do_reset();
    src_valid  = 1'b0;
    src_valid1 = 1'b0;
    rst_n      = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk_src);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk_src);
    #1;
  endtask

  // Offer one word while idle; returns 1 time unit after the accepting edge.
  task automatic accept_word(input logic [31:0] w);
    @(posedge clk_src); #1;
    src_valid = 1'b1;
    src_data  = w;
    @(posedge clk_src); #1;
    src_valid = 1'b0;
  endtask

  // Step clk_src until src_done is seen; counts cycles where ready was wrongly high.
  task automatic wait_done(input int max_cyc, input bit toggle, output int cyc, output int ready_bad);
    cyc = 0;
    ready_bad = 0;
    while (!src_done && cyc < max_cyc) begin
      if (src_ready) ready_bad++;
      if (toggle) src_data = ~src_data;
      @(posedge clk_src); #1;
      cyc++;
    end
  endtask

  // Hold src_valid high, new word every cycle, until n transfers complete.
  task automatic run_stream(input int n, input bit rnd, output int got);
    int          cyc;
    logic [31:0] w;
    cyc = 0;
    w   = 32'h0000_1000;
    got = 0;
    @(posedge clk_src); #1;
    src_valid = 1'b1;
    src_data  = rnd ? $urandom() : w;
    while (got < n && cyc < n * 400) begin
      @(posedge clk_src); #1;
      cyc++;
      if (src_done) got++;
      if (got == n) src_valid = 1'b0;
      else begin
        w++;
        src_data = rnd ? $urandom() : w;
      end
    end
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (src_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b, required 1", src_ready); end
    checks++; if (src_done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b, required 0", src_done); end
    checks++; if (xfer_cnt !== 16'd0)  begin errors++; $display("FAIL reset_cnt: got %0d, required 0", xfer_cnt); end
    checks++; if (dst_valid !== 1'b0)  begin errors++; $display("FAIL reset_dst_valid: got %b, required 0", dst_valid); end
    checks++; if (dst_data !== 32'h0)  begin errors++; $display("FAIL reset_dst_data: got %h, required 0", dst_data); end
  endtask

  task automatic test_basic();
    int cyc, bad, dv0, d0;
    dv0 = n_dv;
    d0  = n_done;
    accept_word(32'hDEAD_BEEF);
    wait_done(300, 1'b0, cyc, bad);
    checks++; if (cyc >= 300)         begin errors++; $display("FAIL basic_timeout: no src_done in %0d cycles", cyc); end
    checks++; if (bad != 0)           begin errors++; $display("FAIL basic_ready_in_wait: high %0d cycles, required 0", bad); end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_at_done: got %b, required 1", src_ready); end
    checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt: got %0d, required 1", xfer_cnt); end
    repeat (20) @(posedge clk_src); #1;
    checks++; if (n_dv - dv0 != 1)    begin errors++; $display("FAIL basic_dst_count: got %0d, required 1", n_dv - dv0); end
    checks++; if (n_done - d0 != 1)   begin errors++; $display("FAIL basic_done_count: got %0d, required 1", n_done - d0); end
    checks++; if (dst_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_dst_data: got %h, required deadbeef", dst_data); end
  endtask

  // Two instances fed at the same clk_src edge: 2-stage sees dst_valid after dst edge 3, 3-stage after edge 4.
  task automatic test_sync_latency();
    int lat0, lat1;
    lat0 = 0;
    lat1 = 0;
    @(posedge clk_src); #1;
    src_valid  = 1'b1; src_data  = 32'h1111_2222;
    src_valid1 = 1'b1; src_data1 = 32'h3333_4444;
    @(posedge clk_src);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_dst); #1;
      src_valid  = 1'b0;
      src_valid1 = 1'b0;
      if (dst_valid  && lat0 == 0) lat0 = k;
      if (dst_valid1 && lat1 == 0) lat1 = k;
    end
    repeat (30) @(posedge clk_src); #1;
    checks++; if (lat0 != 3) begin errors++; $display("FAIL latency_sync2: got %0d clk_dst edges, required 3", lat0); end
    checks++; if (lat1 != 4) begin errors++; $display("FAIL latency_sync3: got %0d clk_dst edges, required 4", lat1); end
    checks++; if (dst_data1 !== 32'h3333_4444) begin errors++; $display("FAIL latency_sync3_data: got %h, required 33334444", dst_data1); end
  endtask

  task automatic test_back_to_back();
    int got, dv0;
    do_reset();
    dv0 = n_dv;
    run_stream(100, 1'b0, got);
    repeat (5) @(posedge clk_src); #1;
    checks++; if (got != 100)           begin errors++; $display("FAIL b2b_done_count: got %0d, required 100", got); end
    checks++; if (xfer_cnt !== 16'd100) begin errors++; $display("FAIL b2b_cnt: got %0d, required 100", xfer_cnt); end
    checks++; if (n_dv - dv0 != 100)    begin errors++; $display("FAIL b2b_dst_count: got %0d, required 100", n_dv - dv0); end
    checks++; if (sb.size() != 0)       begin errors++; $display("FAIL b2b_outstanding: got %0d words, required 0", sb.size()); end
  endtask

  task automatic test_wait_data_change();
    int cyc, bad;
    accept_word(32'h1234_5678);
    wait_done(300, 1'b1, cyc, bad);
    checks++; if (cyc >= 300) begin errors++; $display("FAIL waitchg_timeout: no src_done in %0d cycles", cyc); end
    checks++; if (dst_data !== 32'h1234_5678) begin errors++; $display("FAIL waitchg_dst_data: got %h, required 12345678", dst_data); end
  endtask

  task automatic test_reset_mid_transfer();
    int cyc, bad, dv0, d0;
    accept_word(32'hA5A5_0001);
    @(posedge clk_src); #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_in_reset: got %b, required 1", src_ready); end
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt_in_reset: got %0d, required 0", xfer_cnt); end
    repeat (3) @(posedge clk_src);
    #2 rst_n = 1'b1;
    dv0 = n_dv;
    d0  = n_done;
    repeat (40) @(posedge clk_src); #1;
    checks++; if (n_dv != dv0)        begin errors++; $display("FAIL rstmid_spurious_dst: got %0d pulses, required 0", n_dv - dv0); end
    checks++; if (n_done != d0)       begin errors++; $display("FAIL rstmid_spurious_done: got %0d pulses, required 0", n_done - d0); end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", src_ready); end
    accept_word(32'hCAFE_F00D);
    wait_done(300, 1'b0, cyc, bad);
    checks++; if (cyc >= 300)         begin errors++; $display("FAIL rstmid_timeout: no src_done in %0d cycles", cyc); end
    checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_cnt: got %0d, required 1", xfer_cnt); end
    checks++; if (dst_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstmid_dst_data: got %h, required cafef00d", dst_data); end
  endtask

  task automatic test_cnt_wrap();
    int got, cyc;
    got = 0;
    cyc = 0;
    @(posedge clk_src); #1;
    src_valid1 = 1'b1;
    src_data1  = 32'h0;
    while (got < 17 && cyc < 10000) begin
      @(posedge clk_src); #1;
      cyc++;
      if (src_done1) got++;
      if (got == 17) src_valid1 = 1'b0;
      else src_data1 = src_data1 + 32'd1;
    end
    src_valid1 = 1'b0;
    repeat (5) @(posedge clk_src); #1;
    checks++; if (got != 17)          begin errors++; $display("FAIL wrap_done_count: got %0d, required 17", got); end
    checks++; if (xfer_cnt1 !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d, required 1", xfer_cnt1); end
  endtask

  task automatic test_ratio_sweep();
    int got, n, dv0, d0;
    for (int cfg = 0; cfg < 3; cfg++) begin
      case (cfg)
        0: dst_half = 1.25;
        1: dst_half = 20.0;
        default: begin
          // equal frequency, phase shifted by one shortened half period
          @(posedge clk_dst);
          dst_half = 3.3;
          @(negedge clk_dst);
          dst_half = 5.0;
        end
      endcase
      repeat (10) @(posedge clk_src); #1;
      n   = (cfg == 2) ? 334 : 333;
      dv0 = n_dv;
      d0  = n_done;
      run_stream(n, 1'b1, got);
      repeat (10) @(posedge clk_src); #1;
      checks++; if (got != n)          begin errors++; $display("FAIL ratio%0d_done_count: got %0d, required %0d", cfg, got, n); end
      checks++; if (n_dv - dv0 != n)   begin errors++; $display("FAIL ratio%0d_dst_count: got %0d, required %0d", cfg, n_dv - dv0, n); end
      checks++; if (n_done - d0 != n)  begin errors++; $display("FAIL ratio%0d_done_pulses: got %0d, required %0d", cfg, n_done - d0, n); end
      checks++; if (sb.size() != 0)    begin errors++; $display("FAIL ratio%0d_outstanding: got %0d words, required 0", cfg, sb.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sync_latency();
    test_back_to_back();
    test_wait_data_change();
    test_reset_mid_transfer();
    test_cnt_wrap();
    test_ratio_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
